// File: rtl/arp_pkg.sv
// Shared constants, state encoding and key helper for the arpeggiator scheduler.
package arp_pkg;

    localparam int         NUM_KEYS   = 12;
    localparam logic [3:0] NOTE_NONE  = 4'hF;
    localparam logic [3:0] LAST_RESET = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } arp_state_e;

    // Returns whether the key for note code 'code' is held (keys[11] is note 0).
    function automatic logic key_held(input logic [NUM_KEYS-1:0] keys, input logic [3:0] code);
        logic held;
        held = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (code == 4'(NUM_KEYS - 1 - i)) begin
                held = keys[i];
            end
        end
        return held;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin note picker: lowest held code above 'last', else lowest held code.
module rr_pick
    import arp_pkg::*;
(
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [3:0]          last,
    output logic [3:0]          next_code,
    output logic                found
);

    logic [NUM_KEYS-1:0] held_by_code;
    logic [NUM_KEYS-1:0] above_last;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_map
            // Re-index so bit position equals note code.
            assign held_by_code[gi] = keys[NUM_KEYS-1-gi];
            assign above_last[gi]   = held_by_code[gi] && (4'(gi) > last);
        end
    endgenerate

    // Priority-encode the lowest candidate; candidates above 'last' take precedence.
    always_comb begin
        next_code = NOTE_NONE;
        found     = |held_by_code;
        if (|above_last) begin
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                if (above_last[i]) begin
                    next_code = 4'(i);
                end
            end
        end else begin
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                if (held_by_code[i]) begin
                    next_code = 4'(i);
                end
            end
        end
    end

endmodule

// File: rtl/arp_scheduler.sv
// Arpeggiator scheduler: cycles through held keys with per-note dwell and gap timing.
module arp_scheduler
    import arp_pkg::*;
#(
    parameter int TICK_DIV = 10000
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic [3:0]          octave_in,
    input  logic [7:0]          dwell,
    input  logic [3:0]          gap,
    output logic [3:0]          note,
    output logic [3:0]          octave,
    output logic                step
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    arp_state_e  state_q, state_d;
    logic [3:0]  note_q, note_d;
    logic [3:0]  octave_q, octave_d;
    logic        step_q, step_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  tick_q, tick_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [3:0]  gap_q, gap_d;

    logic [3:0]  pick_code;
    logic        pick_found;
    logic        tick;
    logic        play_done;
    logic        gap_done;
    logic        cur_held;
    logic        start_note;
    logic        to_gap;
    logic        to_idle;

    rr_pick u_rr_pick (
        .keys      (keys),
        .last      (last_q),
        .next_code (pick_code),
        .found     (pick_found)
    );

    assign tick      = (presc_q == PRESC_LAST);
    assign play_done = tick && (tick_q == dwell_q - 8'd1);
    assign gap_done  = tick && (tick_q == {4'd0, gap_q} - 8'd1);
    assign cur_held  = key_held(keys, note_q);

    // Next-state logic: decide the transition, then apply note-start / gap / idle updates.
    always_comb begin
        state_d    = state_q;
        note_d     = note_q;
        octave_d   = octave_q;
        step_d     = 1'b0;
        last_d     = last_q;
        dwell_d    = dwell_q;
        gap_d      = gap_q;
        presc_d    = tick ? 16'd0 : presc_q + 16'd1;
        tick_d     = tick ? tick_q + 8'd1 : tick_q;
        start_note = 1'b0;
        to_gap     = 1'b0;
        to_idle    = 1'b0;

        if (!en) begin
            to_idle = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) start_note = 1'b1;
                    else            to_idle    = 1'b1;
                end
                PLAY: begin
                    // A released playing key cuts the note short on this cycle.
                    if (!cur_held || play_done) begin
                        if (gap_q != 4'd0 && pick_found) to_gap     = 1'b1;
                        else if (pick_found)             start_note = 1'b1;
                        else                             to_idle    = 1'b1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        if (pick_found) start_note = 1'b1;
                        else            to_idle    = 1'b1;
                    end
                end
                default: to_idle = 1'b1;
            endcase
        end

        if (start_note) begin
            state_d  = PLAY;
            note_d   = pick_code;
            last_d   = pick_code;
            step_d   = 1'b1;
            octave_d = octave_in;
            dwell_d  = (dwell == 8'd0) ? 8'd1 : dwell;
            gap_d    = gap;
            presc_d  = 16'd0;
            tick_d   = 8'd0;
        end else if (to_gap) begin
            state_d = GAP;
            note_d  = NOTE_NONE;
            presc_d = 16'd0;
            tick_d  = 8'd0;
        end else if (to_idle) begin
            state_d = IDLE;
            note_d  = NOTE_NONE;
            presc_d = 16'd0;
            tick_d  = 8'd0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            note_q   <= NOTE_NONE;
            octave_q <= 4'd0;
            step_q   <= 1'b0;
            presc_q  <= 16'd0;
            tick_q   <= 8'd0;
            last_q   <= LAST_RESET;
            dwell_q  <= 8'd1;
            gap_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            note_q   <= note_d;
            octave_q <= octave_d;
            step_q   <= step_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            last_q   <= last_d;
            dwell_q  <= dwell_d;
            gap_q    <= gap_d;
        end
    end

    assign note   = note_q;
    assign octave = octave_q;
    assign step   = step_q;

endmodule

// File: tb/tb_arp_scheduler.sv
// Directed testbench for arp_scheduler with TICK_DIV=4.
module tb_arp_scheduler;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] keys;
    logic [3:0]  octave_in;
    logic [7:0]  dwell;
    logic [3:0]  gap;
    logic [3:0]  note;
    logic [3:0]  octave;
    logic        step;

    int pass_cnt  = 0;
    int total_cnt = 0;

    arp_scheduler #(.TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .keys      (keys),
        .octave_in (octave_in),
        .dwell     (dwell),
        .gap       (gap),
        .note      (note),
        .octave    (octave),
        .step      (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; keys = 12'h000;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; keys = 12'h800; octave_in = 4'd7; dwell = 8'd1; gap = 4'd0;
        cyc(2);
        total_cnt++;
        if (note !== 4'hF) $display("FAIL reset_note: got %h expected %h", note, 4'hF); else pass_cnt++;
        total_cnt++;
        if (octave !== 4'd0) $display("FAIL reset_octave: got %h expected %h", octave, 4'd0); else pass_cnt++;
        total_cnt++;
        if (step !== 1'b0) $display("FAIL reset_step: got %b expected %b", step, 1'b0); else pass_cnt++;
        $display("test_reset: note=%h octave=%h step=%b", note, octave, step);
        rst = 1'b0; en = 1'b0; keys = 12'h000;
        cyc(1);
    endtask

    // C,E,G with dwell=2, gap=1: 8 cycles of note then 4 of silence.
    task automatic test_cycle();
        logic [3:0] seq [4];
        seq[0] = 4'd0; seq[1] = 4'd4; seq[2] = 4'd7; seq[3] = 4'd0;
        do_reset();
        en = 1'b1; keys = 12'h890; dwell = 8'd2; gap = 4'd1; octave_in = 4'd2;
        cyc(1);
        total_cnt++;
        if (octave !== 4'd2) $display("FAIL cycle_octave: got %h expected %h", octave, 4'd2); else pass_cnt++;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 8; i++) begin
                total_cnt++;
                if (note !== seq[n]) $display("FAIL cycle_note n=%0d i=%0d: got %h expected %h", n, i, note, seq[n]); else pass_cnt++;
                total_cnt++;
                if (step !== (i == 0)) $display("FAIL cycle_step n=%0d i=%0d: got %b expected %b", n, i, step, (i == 0)); else pass_cnt++;
                cyc(1);
            end
            for (int i = 0; i < 4; i++) begin
                total_cnt++;
                if (note !== 4'hF) $display("FAIL cycle_gap n=%0d i=%0d: got %h expected %h", n, i, note, 4'hF); else pass_cnt++;
                total_cnt++;
                if (step !== 1'b0) $display("FAIL cycle_gapstep n=%0d i=%0d: got %b expected 0", n, i, step); else pass_cnt++;
                cyc(1);
            end
            $display("test_cycle: note %0d played as %h", n, seq[n]);
        end
    endtask

    // Single key A, gap=0, dwell=1: constant note, step every 4 cycles.
    task automatic test_single();
        do_reset();
        en = 1'b1; keys = 12'h004; dwell = 8'd1; gap = 4'd0; octave_in = 4'd1;
        cyc(1);
        for (int i = 0; i < 12; i++) begin
            total_cnt++;
            if (note !== 4'd9) $display("FAIL single_note i=%0d: got %h expected %h", i, note, 4'd9); else pass_cnt++;
            total_cnt++;
            if (step !== (i % 4 == 0)) $display("FAIL single_step i=%0d: got %b expected %b", i, step, (i % 4 == 0)); else pass_cnt++;
            cyc(1);
        end
        $display("test_single: note=%h", note);
    endtask

    // dwell=0 behaves as dwell=1.
    task automatic test_dwell_zero();
        do_reset();
        en = 1'b1; keys = 12'h004; dwell = 8'd0; gap = 4'd0;
        cyc(1);
        cyc(3);
        total_cnt++;
        if (step !== 1'b0) $display("FAIL dwell0_mid: got %b expected 0", step); else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (step !== 1'b1) $display("FAIL dwell0_step: got %b expected 1", step); else pass_cnt++;
        $display("test_dwell_zero: step=%b note=%h", step, note);
    endtask

    // D playing with dwell=5, released at cycle 3 while F held, gap=0.
    task automatic test_release();
        do_reset();
        en = 1'b1; keys = 12'h240; dwell = 8'd5; gap = 4'd0;
        cyc(1);
        total_cnt++;
        if (note !== 4'd2) $display("FAIL release_first: got %h expected %h", note, 4'd2); else pass_cnt++;
        cyc(3);
        total_cnt++;
        if (note !== 4'd2) $display("FAIL release_hold: got %h expected %h", note, 4'd2); else pass_cnt++;
        keys = 12'h040;
        cyc(1);
        total_cnt++;
        if (note !== 4'd5) $display("FAIL release_next: got %h expected %h", note, 4'd5); else pass_cnt++;
        total_cnt++;
        if (step !== 1'b1) $display("FAIL release_step: got %b expected 1", step); else pass_cnt++;
        $display("test_release: note=%h step=%b", note, step);
    endtask

    // All keys released in GAP: silence until gap expiry, then IDLE.
    task automatic test_gap_release();
        do_reset();
        en = 1'b1; keys = 12'h800; dwell = 8'd1; gap = 4'd2;
        cyc(1);
        total_cnt++;
        if (note !== 4'd0) $display("FAIL gaprel_first: got %h expected %h", note, 4'd0); else pass_cnt++;
        cyc(4);
        total_cnt++;
        if (note !== 4'hF) $display("FAIL gaprel_ingap: got %h expected %h", note, 4'hF); else pass_cnt++;
        keys = 12'h000;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            total_cnt++;
            if (note !== 4'hF || step !== 1'b0) $display("FAIL gaprel_silent i=%0d: got %h/%b expected %h/0", i, note, step, 4'hF); else pass_cnt++;
        end
        keys = 12'h800;
        cyc(1);
        total_cnt++;
        if (note !== 4'd0 || step !== 1'b1) $display("FAIL gaprel_restart: got %h/%b expected 0/1", note, step); else pass_cnt++;
        $display("test_gap_release: note=%h", note);
    endtask

    // rst mid-PLAY, then B,C held gives first note 0.
    task automatic test_reset_mid();
        do_reset();
        en = 1'b1; keys = 12'h880; dwell = 8'd4; gap = 4'd0; octave_in = 4'd6;
        cyc(1);
        cyc(5);
        total_cnt++;
        if (note !== 4'd0) $display("FAIL rstmid_play: got %h expected %h", note, 4'd0); else pass_cnt++;
        rst = 1'b1; keys = 12'h801;
        cyc(1);
        total_cnt++;
        if (note !== 4'hF) $display("FAIL rstmid_note: got %h expected %h", note, 4'hF); else pass_cnt++;
        total_cnt++;
        if (octave !== 4'd0) $display("FAIL rstmid_octave: got %h expected %h", octave, 4'd0); else pass_cnt++;
        rst = 1'b0;
        cyc(1);
        total_cnt++;
        if (note !== 4'd0) $display("FAIL rstmid_first: got %h expected %h", note, 4'd0); else pass_cnt++;
        total_cnt++;
        if (octave !== 4'd6) $display("FAIL rstmid_oct6: got %h expected %h", octave, 4'd6); else pass_cnt++;
        $display("test_reset_mid: note=%h octave=%h", note, octave);
    endtask

    // octave_in changes mid-note; output follows only at the next step.
    task automatic test_octave();
        do_reset();
        en = 1'b1; keys = 12'h010; dwell = 8'd1; gap = 4'd0; octave_in = 4'd3;
        cyc(1);
        total_cnt++;
        if (octave !== 4'd3) $display("FAIL oct_start: got %h expected %h", octave, 4'd3); else pass_cnt++;
        cyc(1);
        octave_in = 4'd5;
        cyc(1);
        total_cnt++;
        if (octave !== 4'd3) $display("FAIL oct_hold1: got %h expected %h", octave, 4'd3); else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (octave !== 4'd3) $display("FAIL oct_hold2: got %h expected %h", octave, 4'd3); else pass_cnt++;
        cyc(1);
        total_cnt++;
        if (octave !== 4'd5 || step !== 1'b1) $display("FAIL oct_update: got %h/%b expected 5/1", octave, step); else pass_cnt++;
        $display("test_octave: octave=%h", octave);
    endtask

    // en=0 mid-PLAY forces silence; re-enable continues from retained last note.
    task automatic test_en_off();
        do_reset();
        en = 1'b1; keys = 12'h880; dwell = 8'd2; gap = 4'd0;
        cyc(1);
        cyc(2);
        en = 1'b0;
        cyc(1);
        total_cnt++;
        if (note !== 4'hF || step !== 1'b0) $display("FAIL enoff_idle: got %h/%b expected %h/0", note, step, 4'hF); else pass_cnt++;
        en = 1'b1;
        cyc(1);
        total_cnt++;
        if (note !== 4'd4 || step !== 1'b1) $display("FAIL enoff_resume: got %h/%b expected 4/1", note, step); else pass_cnt++;
        $display("test_en_off: note=%h", note);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; keys = 12'h000; octave_in = 4'd0; dwell = 8'd1; gap = 4'd0;
        test_reset();
        test_cycle();
        test_single();
        test_dwell_zero();
        test_release();
        test_gap_release();
        test_reset_mid();
        test_octave();
        test_en_off();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
